// File: rtl/rr_log_packer_pkg.sv
// Shared constants, width helpers and serializer state type for rr_log_packer.
package rr_log_packer_pkg;

    localparam int STAT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic int calc_hdr_w(input int logb_cnt, input int loge_cnt);
        return logb_cnt + loge_cnt;
    endfunction

    function automatic int calc_rec_w(input int logb_cnt, input int loge_cnt, input int data_w);
        return calc_hdr_w(logb_cnt, loge_cnt) + data_w;
    endfunction

    function automatic int calc_nbeats(input int rec_w, input int out_w);
        return (rec_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/rr_log_packer_if.sv
// Recorder-side logging bus plus beat output stream of rr_log_packer.
// Stats outputs exist only when RR_LOG_PACKER_STATS_EN is defined.
interface rr_log_packer_if #(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 5,
    parameter int LOGB_DATA_WIDTH  = 600,
    parameter int OUT_WIDTH        = 512,
    parameter int FIFO_DEPTH       = 16
);
    logic [LOGB_CHANNEL_CNT-1:0]     logb_valid;
    logic [LOGB_DATA_WIDTH-1:0]      logb_data;
    logic [LOGE_CHANNEL_CNT-1:0]     loge_valid;
    logic                            logb_almful;
    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_WIDTH-1:0]            out_data;
    logic                            out_last;
    logic                            err_overflow;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
`ifdef RR_LOG_PACKER_STATS_EN
    logic [31:0]                     stat_records;
    logic [31:0]                     stat_drops;
    logic [31:0]                     stat_stall_cycles;
`endif

    modport master (
        output logb_valid, logb_data, loge_valid, out_ready,
        input  logb_almful, out_valid, out_data, out_last, err_overflow, fifo_count
`ifdef RR_LOG_PACKER_STATS_EN
        , input stat_records, stat_drops, stat_stall_cycles
`endif
    );

    modport slave (
        input  logb_valid, logb_data, loge_valid, out_ready,
        output logb_almful, out_valid, out_data, out_last, err_overflow, fifo_count
`ifdef RR_LOG_PACKER_STATS_EN
        , output stat_records, stat_drops, stat_stall_cycles
`endif
    );

endinterface

// File: rtl/rr_record_fifo.sv
// First-word-fall-through record FIFO; a push while full is legal only with a same-cycle pop.
module rr_record_fifo #(
    parameter int WIDTH = 608,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rr_log_packer.sv
// Packs active recorder cycles into records, buffers them and streams OUT_WIDTH-bit beats.
// Optional counters enabled by defining RR_LOG_PACKER_STATS_EN.
module rr_log_packer
    import rr_log_packer_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 5,
    parameter int LOGB_DATA_WIDTH  = 600,
    parameter int OUT_WIDTH        = 512,
    parameter int FIFO_DEPTH       = 16,
    parameter int ALMFUL_MARGIN    = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_log_packer_if.slave bus
);
    localparam int REC_W  = calc_rec_w(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT, LOGB_DATA_WIDTH);
    localparam int NBEATS = calc_nbeats(REC_W, OUT_WIDTH);
    localparam int PAD_W  = NBEATS * OUT_WIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] head;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             last_beat;

    ser_state_e       state_q;
    logic [PAD_W-1:0] sreg_q;
    logic [BW-1:0]    beat_q;
    logic             valid_q;
    logic             last_q;
    logic             almful_q;
    logic             ovf_q;

    assign rec       = {bus.logb_data, bus.loge_valid, bus.logb_valid};
    assign push_req  = (|bus.logb_valid) | (|bus.loge_valid);
    assign last_beat = (beat_q == BW'(NBEATS - 1));

    // The serializer pops on entry from IDLE and on acceptance of a record's last beat.
    assign pop     = !empty && ((state_q == IDLE) || (bus.out_ready && last_beat));
    assign push_ok = push_req && (!full || pop);
    assign count_d = count + CW'(push_ok) - CW'(pop);

    rr_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .wdata_i (rec),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almful_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            almful_q <= (count_d >= CW'(FIFO_DEPTH - ALMFUL_MARGIN));
            if (push_req && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (pop) begin
                sreg_q  <= PAD_W'(head);
                beat_q  <= '0;
                valid_q <= 1'b1;
                last_q  <= (NBEATS == 1);
                state_q <= SEND;
            end else if (state_q == SEND && bus.out_ready) begin
                if (last_beat) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    beat_q  <= beat_q + 1'b1;
                    sreg_q  <= sreg_q >> OUT_WIDTH;
                    last_q  <= ((beat_q + 1'b1) == BW'(NBEATS - 1));
                end
            end
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_last     = last_q;
    assign bus.out_data     = sreg_q[OUT_WIDTH-1:0];
    assign bus.logb_almful  = almful_q;
    assign bus.err_overflow = ovf_q;
    assign bus.fifo_count   = count;

`ifdef RR_LOG_PACKER_STATS_EN
    logic [STAT_W-1:0] stat_records_q;
    logic [STAT_W-1:0] stat_drops_q;
    logic [STAT_W-1:0] stat_stall_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_records_q <= '0;
            stat_drops_q   <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_records_q <= sat_inc(stat_records_q, push_ok);
            stat_drops_q   <= sat_inc(stat_drops_q, push_req && !push_ok);
            stat_stall_q   <= sat_inc(stat_stall_q, valid_q && !bus.out_ready);
        end
    end

    assign bus.stat_records      = stat_records_q;
    assign bus.stat_drops        = stat_drops_q;
    assign bus.stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rr_log_packer.sv
// Scoreboard bench for rr_log_packer: directed records, queued expected beats, negedge monitor.
module tb_rr_log_packer;
    import rr_log_packer_pkg::*;

    localparam int LB    = 3;
    localparam int LE    = 5;
    localparam int DW    = 600;
    localparam int OW    = 512;
    localparam int FD    = 16;
    localparam int AM    = 4;
    localparam int REC_W = 608;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_log_packer_if #(.LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .LOGB_DATA_WIDTH(DW),
                       .OUT_WIDTH(OW), .FIFO_DEPTH(FD)) bus ();

    rr_log_packer #(.LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .LOGB_DATA_WIDTH(DW),
                    .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .ALMFUL_MARGIN(AM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t         exp_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] d;
    int            exp_cnt;
    logic [OW-1:0] held_data;

    bit   track = 0;
    int   peak_cnt;
    int   beats_seen;
    bit   gap_seen;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_rec(input logic [LB-1:0] lv, input logic [LE-1:0] ev, input logic [DW-1:0] dat);
        logic [2*OW-1:0] r;
        r = '0;
        r[REC_W-1:0] = {dat, ev, lv};
        exp_q.push_back('{r[OW-1:0], 1'b0});
        exp_q.push_back('{r[2*OW-1:OW], 1'b1});
    endtask

    // Presents one input cycle; entered and left 1 time unit after a rising edge.
    task automatic send(input logic [LB-1:0] lv, input logic [LE-1:0] ev, input logic [DW-1:0] dat);
        bus.logb_valid = lv;
        bus.loge_valid = ev;
        bus.logb_data  = dat;
        @(posedge clk); #1;
        bus.logb_valid = '0;
        bus.loge_valid = '0;
        bus.logb_data  = '0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", OW'(exp_q.size()), '0);
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_valid", OW'(bus.out_valid), OW'(1));
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_unexpected: got %0h want none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", bus.out_data, e.data);
                chk("beat_last", OW'(bus.out_last), OW'(e.last));
            end
        end
        if (track) begin
            if (int'(bus.fifo_count) > peak_cnt) peak_cnt = int'(bus.fifo_count);
            if (bus.out_valid === 1'b1) begin
                beats_seen++;
                if (gap_seen) gap_seen = 1'b1;
            end else if (beats_seen > 0 && beats_seen < 8) begin
                gap_seen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.logb_valid = '0;
        bus.loge_valid = '0;
        bus.logb_data  = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", OW'(bus.out_valid), '0);
        chk("rst_out_last", OW'(bus.out_last), '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_almful", OW'(bus.logb_almful), '0);
        chk("rst_err", OW'(bus.err_overflow), '0);
        chk("rst_count", OW'(bus.fifo_count), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single record: header 0x09 in the low byte, payload byte 0xA5 above it.
        bus.out_ready = 1'b1;
        exp_q.push_back('{OW'(16'hA509), 1'b0});
        exp_q.push_back('{'0, 1'b1});
        d = '0;
        d[7:0] = 8'hA5;
        send(3'b001, 5'b00001, d);
        chk("lat_e0_valid", OW'(bus.out_valid), '0);
        @(posedge clk); #1;
        chk("lat_e1_valid", OW'(bus.out_valid), OW'(1));
        wait_drain(20);
        @(posedge clk); #1;
        chk("single_idle_after", OW'(bus.out_valid), '0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_count", OW'(bus.fifo_count), '0);
            chk("idle_valid", OW'(bus.out_valid), '0);
        end

        // Back-to-back records with ready held high.
        peak_cnt   = 0;
        beats_seen = 0;
        gap_seen   = 1'b0;
        track      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = '0;
            d[31:0]    = 32'hC0DE0000 + k;
            d[599:568] = 32'hF00D0000 + k;
            expect_rec(3'(k + 1), 5'(1 << k), d);
            send(3'(k + 1), 5'(1 << k), d);
        end
        wait_drain(30);
        repeat (2) @(posedge clk);
        #1;
        track = 1'b0;
        chk("b2b_beats", OW'(beats_seen), OW'(8));
        chk("b2b_gap", OW'(gap_seen), '0);
        chk("b2b_peak_count", OW'(peak_cnt), OW'(2));

        // Stall on beat 0 for three cycles.
        bus.out_ready = 1'b0;
        d = '0;
        d[15:0] = 16'hBEEF;
        expect_rec(3'b100, 5'b00000, d);
        send(3'b100, 5'b00000, d);
        wait_valid(10);
        held_data = exp_q[0].data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", OW'(bus.out_valid), OW'(1));
            chk("stall_data", bus.out_data, held_data);
            chk("stall_last", OW'(bus.out_last), '0);
        end
        bus.out_ready = 1'b1;
        wait_drain(20);

        // Fill under backpressure; record 1 sits in the serializer, so record 18 overflows.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            d = '0;
            d[31:0] = 32'(i);
            if (i <= 17) expect_rec(3'b001, 5'b00000, d);
            send(3'b001, 5'b00000, d);
            exp_cnt = (i == 1) ? 1 : ((i - 1 > 16) ? 16 : i - 1);
            chk("bp_count", OW'(bus.fifo_count), OW'(exp_cnt));
            chk("bp_almful", OW'(bus.logb_almful), OW'(exp_cnt >= 12));
            chk("bp_err", OW'(bus.err_overflow), OW'(i == 18));
        end
`ifdef RR_LOG_PACKER_STATS_EN
        chk("stat_drops", OW'(bus.stat_drops), OW'(1));
`endif
        bus.out_ready = 1'b1;
        wait_drain(100);
        chk("bp_err_sticky", OW'(bus.err_overflow), OW'(1));

        // Reset asserted while beat 1 of a record is on the bus.
        bus.out_ready = 1'b0;
        d = '0;
        d[7:0] = 8'h5A;
        expect_rec(3'b001, 5'b00000, d);
        send(3'b001, 5'b00000, d);
        expect_rec(3'b010, 5'b00000, d);
        send(3'b010, 5'b00000, d);
        @(posedge clk); #1;
        chk("rm_count_before", OW'(bus.fifo_count), OW'(1));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("rm_on_beat1", OW'(bus.out_last), OW'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rm_valid", OW'(bus.out_valid), '0);
        chk("rm_last", OW'(bus.out_last), '0);
        chk("rm_count", OW'(bus.fifo_count), '0);
        chk("rm_err", OW'(bus.err_overflow), '0);
        chk("rm_almful", OW'(bus.logb_almful), '0);
`ifdef RR_LOG_PACKER_STATS_EN
        chk("rm_stat_records", OW'(bus.stat_records), '0);
        chk("rm_stat_drops", OW'(bus.stat_drops), '0);
        chk("rm_stat_stall", OW'(bus.stat_stall_cycles), '0);
`endif
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", OW'(bus.out_valid), '0);
        chk("post_rst_count", OW'(bus.fifo_count), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
